// File: rtl/shift_sub_divider.sv
// shift_sub_divider: restoring shift-subtract divider, signed/unsigned, one quotient bit per clock
module shift_sub_divider #(
    parameter int DIV_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sign,
    input  logic [DIV_WIDTH-1:0] data_in1,
    input  logic [DIV_WIDTH-1:0] data_in2,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 ready,
    output logic                 div_zero,
    output logic                 overflow
);
    localparam int W  = DIV_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
    logic [1:0]   state;
    logic [CW-1:0] cnt;
    logic [W:0]   prem;
    logic [W-1:0] dvd, dvs, raw_a, mag_a, mag_b;
    logic         q_neg, r_neg, dz, ov;
    logic [W+1:0] shifted;
    logic [W:0]   trial;
    logic         ge;
    assign ready   = state == IDLE;
    assign mag_a   = sign && data_in1[W-1] ? -data_in1 : data_in1;
    assign mag_b   = sign && data_in2[W-1] ? -data_in2 : data_in2;
    assign shifted = {prem, dvd[W-1]};
    assign ge      = shifted >= {2'b0, dvs};
    assign trial   = shifted[W:0] - {1'b0, dvs};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            prem      <= '0;
            dvd       <= '0;
            dvs       <= '0;
            raw_a     <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            dz        <= 1'b0;
            ov        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    q_neg <= sign & (data_in1[W-1] ^ data_in2[W-1]);
                    r_neg <= sign & data_in1[W-1];
                    dvd   <= mag_a;
                    dvs   <= mag_b;
                    raw_a <= data_in1;
                    dz    <= data_in2 == '0;
                    ov    <= sign && data_in1 == {1'b1, {(W-1){1'b0}}} && &data_in2;
                    prem  <= '0;
                    cnt   <= CW'(W - 1);
                    state <= CALC;
                end
                CALC: begin
                    prem  <= ge ? trial : shifted[W:0];
                    dvd   <= {dvd[W-2:0], ge};
                    cnt   <= cnt - 1'b1;
                    state <= cnt == '0 ? FIX : CALC;
                end
                FIX: begin
                    // divide-by-zero overrides the natural all-ones quotient and reports the raw dividend
                    quotient  <= dz ? '1 : q_neg ? -dvd : dvd;
                    remainder <= dz ? raw_a : r_neg ? -prem[W-1:0] : prem[W-1:0];
                    div_zero  <= dz;
                    overflow  <= ov;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sub_divider.sv
// tb_shift_sub_divider: directed vectors with a queue scoreboard checked on each ready rise
module tb_shift_sub_divider;
    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        logic       ov;
    } res_t;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, sign = 1'b0;
    logic [3:0] data_in1 = '0, data_in2 = '0, quotient, remainder;
    logic       ready, div_zero, overflow;
    res_t       exp_q[$];
    int         checks = 0, errors = 0, busy = 0;
    logic       prev_ready = 1'b1, aborting = 1'b1;
    shift_sub_divider #(.DIV_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sign(sign),
        .data_in1(data_in1), .data_in2(data_in2),
        .quotient(quotient), .remainder(remainder),
        .ready(ready), .div_zero(div_zero), .overflow(overflow)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask
    // monitor: every completion (ready rise outside a reset) pops one expected result
    always @(negedge clk) begin
        res_t e;
        if (ready !== 1'b1) busy++;
        else if (!prev_ready) begin
            if (!aborting) begin
                chk("latency", 8'(busy), 8'd5);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result q=%h r=%h expected none", quotient, remainder);
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient", {4'h0, quotient}, {4'h0, e.q});
                    chk("remainder", {4'h0, remainder}, {4'h0, e.r});
                    chk("div_zero", {7'h0, div_zero}, {7'h0, e.dz});
                    chk("overflow", {7'h0, overflow}, {7'h0, e.ov});
                end
            end
            busy = 0;
        end
        prev_ready = ready;
    end
    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout ready=%b expected 1", ready);
        end
    endtask
    task automatic issue(input logic s, input logic [3:0] a, input logic [3:0] b);
        wait_ready();
        sign = s;
        data_in1 = a;
        data_in2 = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic run(input logic s, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] q, input logic [3:0] r, input logic dz, input logic ov);
        exp_q.push_back('{q: q, r: r, dz: dz, ov: ov});
        issue(s, a, b);
        wait_ready();
    endtask
    task automatic chk_reset_state();
        chk("rst_ready", {7'h0, ready}, 8'h01);
        chk("rst_quotient", {4'h0, quotient}, 8'h00);
        chk("rst_remainder", {4'h0, remainder}, 8'h00);
        chk("rst_div_zero", {7'h0, div_zero}, 8'h00);
        chk("rst_overflow", {7'h0, overflow}, 8'h00);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;
        @(negedge clk);
        aborting = 1'b0;
        run(1'b0, 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b0);
        run(1'b1, 4'h9, 4'd2, 4'hD, 4'hF, 1'b0, 1'b0);
        run(1'b1, 4'd7, 4'hE, 4'hD, 4'd1, 1'b0, 1'b0);
        run(1'b1, 4'hA, 4'hD, 4'd2, 4'd0, 1'b0, 1'b0);
        run(1'b0, 4'd9, 4'd0, 4'hF, 4'd9, 1'b1, 1'b0);
        run(1'b0, 4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 1'b0);
        run(1'b1, 4'h8, 4'hF, 4'h8, 4'd0, 1'b0, 1'b1);
        run(1'b0, 4'd8, 4'd15, 4'd0, 4'd8, 1'b0, 1'b0);
        run(1'b1, 4'h8, 4'd3, 4'hE, 4'hE, 1'b0, 1'b0);
        run(1'b1, 4'hB, 4'd0, 4'hF, 4'hB, 1'b1, 1'b0);
        exp_q.push_back('{q: 4'd3, r: 4'd2, dz: 1'b0, ov: 1'b0});
        issue(1'b0, 4'd14, 4'd4);
        @(negedge clk);
        sign = 1'b1;
        data_in1 = 4'd15;
        data_in2 = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ready();
        repeat (8) @(negedge clk);
        issue(1'b0, 4'd13, 4'd3);
        repeat (2) @(negedge clk);
        aborting = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        aborting = 1'b0;
        run(1'b0, 4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 1'b0);
        @(negedge clk);
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
